// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the two-master SRAM arbiter: HTRANS codes,
// arbiter FSM encoding and performance-counter width.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int ARB_CNT_W = 16;

  // Encoding doubles as the owner output: 00 none, 01 M0, 10 M1.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_OWN_M0 = 2'b01,
    ARB_OWN_M1 = 2'b10
  } arb_state_t;

  localparam logic GRANT_M0 = 1'b0;
  localparam logic GRANT_M1 = 1'b1;

endpackage

// File: rtl/ahb_sram_arb_pick.sv
// Combinational next-owner selection for the SRAM arbiter: round-robin
// on ties from IDLE, burst-hold cap while the other master waits.
module ahb_sram_arb_pick
  import ahb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 2
) (
  input  logic              req0,
  input  logic              req1,
  input  arb_state_t        state,
  input  logic              last_grant,
  input  logic [HOLD_W-1:0] hold_cnt,
  input  logic              acc,
  output arb_state_t        next_state,
  output logic              next_last_grant,
  output logic [HOLD_W-1:0] next_hold
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  logic own_req;
  logic oth_req;

  always_comb begin
    own_req = 1'b0;
    oth_req = 1'b0;
    if (state == ARB_OWN_M0) begin
      own_req = req0;
      oth_req = req1;
    end else if (state == ARB_OWN_M1) begin
      own_req = req1;
      oth_req = req0;
    end
  end

  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    next_hold       = hold_cnt;
    case (state)
      ARB_IDLE: begin
        // On a tie the master that was not granted last time wins.
        if (req0 && (!req1 || last_grant == GRANT_M1)) begin
          next_state      = ARB_OWN_M0;
          next_last_grant = GRANT_M0;
          next_hold       = '0;
        end else if (req1) begin
          next_state      = ARB_OWN_M1;
          next_last_grant = GRANT_M1;
          next_hold       = '0;
        end
      end
      default: begin
        // A stalled owner that is still requesting keeps everything frozen.
        if (acc || !own_req) begin
          if (oth_req && (!own_req || hold_cnt == HOLD_MAX)) begin
            next_state      = (state == ARB_OWN_M0) ? ARB_OWN_M1 : ARB_OWN_M0;
            next_last_grant = (state == ARB_OWN_M0) ? GRANT_M1 : GRANT_M0;
            next_hold       = '0;
          end else if (own_req) begin
            if (hold_cnt != HOLD_MAX) next_hold = hold_cnt + HOLD_W'(1);
          end else begin
            next_state = ARB_IDLE;
            next_hold  = '0;
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_arbiter.sv
// Two-master AHB arbiter in front of the SRAM controller port.
// Optional per-master beat counters are enabled with SRAM_ARB_PERF_CNT_EN.
module ahb_sram_arbiter
  import ahb_pkg::*;
#(
  parameter int ADDR_W   = 21,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [ADDR_W-1:0] m0_HADDR,
  input  logic              m0_HWRITE,
  input  logic [1:0]        m0_HTRANS,
  input  logic [DATA_W-1:0] m0_HWDATA,
  output logic              m0_HREADY,
  output logic [DATA_W-1:0] m0_HRDATA,
  output logic              m0_HRVALID,
  input  logic [ADDR_W-1:0] m1_HADDR,
  input  logic              m1_HWRITE,
  input  logic [1:0]        m1_HTRANS,
  input  logic [DATA_W-1:0] m1_HWDATA,
  output logic              m1_HREADY,
  output logic [DATA_W-1:0] m1_HRDATA,
  output logic              m1_HRVALID,
  output logic [ADDR_W-1:0] s_HADDR,
  output logic              s_HWRITE,
  output logic [1:0]        s_HTRANS,
  output logic [DATA_W-1:0] s_HWDATA,
  input  logic              s_HREADY,
  input  logic [DATA_W-1:0] s_HRDATA,
  output logic [1:0]        owner
`ifdef SRAM_ARB_PERF_CNT_EN
  ,
  output logic [ARB_CNT_W-1:0] m0_beat_cnt,
  output logic [ARB_CNT_W-1:0] m1_beat_cnt
`endif
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_t        state;
  arb_state_t        next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] next_hold;
  logic              last_grant;
  logic              next_last_grant;
  logic              rd_pend;
  logic              rd_owner;
  logic              req0;
  logic              req1;
  logic              acc;

  assign req0  = m0_HTRANS[1];
  assign req1  = m1_HTRANS[1];
  assign owner = state;

  assign acc = s_HREADY && ((state == ARB_OWN_M0 && req0) || (state == ARB_OWN_M1 && req1));

  ahb_sram_arb_pick #(
    .MAX_HOLD(MAX_HOLD),
    .HOLD_W  (HOLD_W)
  ) u_pick (
    .req0           (req0),
    .req1           (req1),
    .state          (state),
    .last_grant     (last_grant),
    .hold_cnt       (hold_cnt),
    .acc            (acc),
    .next_state     (next_state),
    .next_last_grant(next_last_grant),
    .next_hold      (next_hold)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= ARB_IDLE;
      hold_cnt   <= '0;
      last_grant <= GRANT_M1;
      rd_pend    <= 1'b0;
      rd_owner   <= GRANT_M0;
    end else begin
      state      <= next_state;
      hold_cnt   <= next_hold;
      last_grant <= next_last_grant;
      rd_pend    <= acc && !s_HWRITE;
      if (acc) rd_owner <= (state == ARB_OWN_M1);
    end
  end

  always_comb begin
    s_HADDR  = '0;
    s_HWRITE = 1'b0;
    s_HTRANS = HTRANS_IDLE;
    s_HWDATA = '0;
    case (state)
      ARB_OWN_M0: begin
        s_HADDR  = m0_HADDR;
        s_HWRITE = m0_HWRITE;
        s_HTRANS = m0_HTRANS;
        s_HWDATA = m0_HWDATA;
      end
      ARB_OWN_M1: begin
        s_HADDR  = m1_HADDR;
        s_HWRITE = m1_HWRITE;
        s_HTRANS = m1_HTRANS;
        s_HWDATA = m1_HWDATA;
      end
      default: ;
    endcase
  end

  // A non-owner that is not requesting sees HREADY=1 so its bus stays idle-ready.
  assign m0_HREADY  = (state == ARB_OWN_M0) ? s_HREADY : !req0;
  assign m1_HREADY  = (state == ARB_OWN_M1) ? s_HREADY : !req1;
  assign m0_HRDATA  = s_HRDATA;
  assign m1_HRDATA  = s_HRDATA;
  assign m0_HRVALID = rd_pend && (rd_owner == GRANT_M0);
  assign m1_HRVALID = rd_pend && (rd_owner == GRANT_M1);

`ifdef SRAM_ARB_PERF_CNT_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      m0_beat_cnt <= '0;
      m1_beat_cnt <= '0;
    end else begin
      if (acc && state == ARB_OWN_M0 && m0_beat_cnt != '1) m0_beat_cnt <= m0_beat_cnt + 1'b1;
      if (acc && state == ARB_OWN_M1 && m1_beat_cnt != '1) m1_beat_cnt <= m1_beat_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Directed self-checking bench for ahb_sram_arbiter: reset, single-master
// write, round-robin with hold cap, read return routing, stall, async reset.
module tb_ahb_sram_arbiter;
  import ahb_pkg::*;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;

  logic              HCLK;
  logic              HRESET;
  logic [ADDR_W-1:0] m0_HADDR, m1_HADDR;
  logic              m0_HWRITE, m1_HWRITE;
  logic [1:0]        m0_HTRANS, m1_HTRANS;
  logic [DATA_W-1:0] m0_HWDATA, m1_HWDATA;
  logic              m0_HREADY, m1_HREADY;
  logic [DATA_W-1:0] m0_HRDATA, m1_HRDATA;
  logic              m0_HRVALID, m1_HRVALID;
  logic [ADDR_W-1:0] s_HADDR;
  logic              s_HWRITE;
  logic [1:0]        s_HTRANS;
  logic [DATA_W-1:0] s_HWDATA;
  logic              s_HREADY;
  logic [DATA_W-1:0] s_HRDATA;
  logic [1:0]        owner;
`ifdef SRAM_ARB_PERF_CNT_EN
  logic [ARB_CNT_W-1:0] m0_beat_cnt, m1_beat_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

  ahb_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m0_HADDR(m0_HADDR), .m0_HWRITE(m0_HWRITE), .m0_HTRANS(m0_HTRANS), .m0_HWDATA(m0_HWDATA),
    .m0_HREADY(m0_HREADY), .m0_HRDATA(m0_HRDATA), .m0_HRVALID(m0_HRVALID),
    .m1_HADDR(m1_HADDR), .m1_HWRITE(m1_HWRITE), .m1_HTRANS(m1_HTRANS), .m1_HWDATA(m1_HWDATA),
    .m1_HREADY(m1_HREADY), .m1_HRDATA(m1_HRDATA), .m1_HRVALID(m1_HRVALID),
    .s_HADDR(s_HADDR), .s_HWRITE(s_HWRITE), .s_HTRANS(s_HTRANS), .s_HWDATA(s_HWDATA),
    .s_HREADY(s_HREADY), .s_HRDATA(s_HRDATA), .owner(owner)
`ifdef SRAM_ARB_PERF_CNT_EN
    , .m0_beat_cnt(m0_beat_cnt), .m1_beat_cnt(m1_beat_cnt)
`endif
  );

  // Clock / reset
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_m0(input logic [1:0] trans, input logic wr,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    m0_HTRANS = trans;
    m0_HWRITE = wr;
    m0_HADDR  = addr;
    m0_HWDATA = wdata;
  endtask

  task automatic drive_m1(input logic [1:0] trans, input logic wr,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    m1_HTRANS = trans;
    m1_HWRITE = wr;
    m1_HADDR  = addr;
    m1_HWDATA = wdata;
  endtask

  task automatic do_reset();
    drive_m0(HTRANS_IDLE, 1'b0, '0, '0);
    drive_m1(HTRANS_IDLE, 1'b0, '0, '0);
    s_HREADY = 1'b1;
    s_HRDATA = '0;
    HRESET   = 1'b1;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  initial begin
    int exp_own;
    HRESET   = 1'b0;
    s_HREADY = 1'b1;
    s_HRDATA = '0;
    drive_m0(HTRANS_IDLE, 1'b0, '0, '0);
    drive_m1(HTRANS_IDLE, 1'b0, '0, '0);
    #1;

    // Reset with M0 requesting
    HRESET = 1'b1;
    drive_m0(HTRANS_NONSEQ, 1'b1, 21'd3, 8'hA5);
    #1;
    check_eq("rst_s_htrans", 32'(s_HTRANS), 32'h0);
    check_eq("rst_owner", 32'(owner), 32'h0);
    check_eq("rst_m0_hready", 32'(m0_HREADY), 32'h0);
    check_eq("rst_m0_hrvalid", 32'(m0_HRVALID), 32'h0);
    check_eq("rst_m1_hrvalid", 32'(m1_HRVALID), 32'h0);
    tick();
    tick();
    HRESET = 1'b0;

    // M0 alone writes addr 3 / 0xA5
    settle();
    check_eq("wr_idle_bubble", 32'(s_HTRANS), 32'h0);
    tick();
    settle();
    check_eq("wr_owner", 32'(owner), 32'h1);
    check_eq("wr_s_haddr", 32'(s_HADDR), 32'h3);
    check_eq("wr_s_hwrite", 32'(s_HWRITE), 32'h1);
    check_eq("wr_s_hwdata", 32'(s_HWDATA), 32'hA5);
    check_eq("wr_s_htrans", 32'(s_HTRANS), 32'h2);
    check_eq("wr_m0_hready", 32'(m0_HREADY), 32'h1);
    check_eq("wr_m1_hready", 32'(m1_HREADY), 32'h1);
    tick();
    drive_m0(HTRANS_IDLE, 1'b0, '0, '0);
    tick();
    settle();
    check_eq("wr_back_idle", 32'(owner), 32'h0);

    // Both requesting continuously: bubble, then 4/4 alternation
    do_reset();
    drive_m0(HTRANS_NONSEQ, 1'b1, 21'h10, 8'h11);
    drive_m1(HTRANS_NONSEQ, 1'b1, 21'h20, 8'h22);
    for (int k = 0; k <= 32; k++) begin
      settle();
      if (k == 0) begin
        check_eq("rr_bubble", 32'(owner), 32'h0);
      end else begin
        exp_own = (((k - 1) / 4) % 2 == 0) ? 1 : 2;
        check_eq("rr_owner", 32'(owner), 32'(exp_own));
        check_eq("rr_haddr", 32'(s_HADDR), (exp_own == 1) ? 32'h10 : 32'h20);
        check_eq("rr_loser_hready", (exp_own == 1) ? 32'(m1_HREADY) : 32'(m0_HREADY), 32'h0);
      end
      tick();
    end
`ifdef SRAM_ARB_PERF_CNT_EN
    check_eq("perf_m0", 32'(m0_beat_cnt), 32'd16);
    check_eq("perf_m1", 32'(m1_beat_cnt), 32'd16);
`endif

    // M1 read, data back on the following cycle
    do_reset();
    drive_m1(HTRANS_NONSEQ, 1'b0, 21'd2, 8'h00);
    settle();
    check_eq("rd_m1_wait", 32'(m1_HREADY), 32'h0);
    tick();
    settle();
    check_eq("rd_owner", 32'(owner), 32'h2);
    check_eq("rd_s_haddr", 32'(s_HADDR), 32'h2);
    check_eq("rd_s_hwrite", 32'(s_HWRITE), 32'h0);
    check_eq("rd_m1_hready", 32'(m1_HREADY), 32'h1);
    exp_q.push_back(8'h5C);
    tick();
    drive_m1(HTRANS_IDLE, 1'b0, '0, '0);
    s_HRDATA = 8'h5C;
    settle();
    check_eq("rd_m1_hrvalid", 32'(m1_HRVALID), 32'h1);
    check_eq("rd_m0_hrvalid", 32'(m0_HRVALID), 32'h0);
    check_eq("rd_m1_hrdata", 32'(m1_HRDATA), 32'(exp_q.pop_front()));
    tick();
    settle();
    check_eq("rd_no_repeat", 32'(m1_HRVALID), 32'h0);

    // M0 write beat then M1 read beat back-to-back
    do_reset();
    drive_m0(HTRANS_NONSEQ, 1'b1, 21'h11, 8'h77);
    drive_m1(HTRANS_NONSEQ, 1'b0, 21'h07, 8'h00);
    tick();
    tick();
    tick();
    tick();
    settle();
    check_eq("b2b_m0_last", 32'(owner), 32'h1);
    check_eq("b2b_m0_write", 32'(s_HWRITE), 32'h1);
    tick();
    settle();
    check_eq("b2b_m1_owner", 32'(owner), 32'h2);
    check_eq("b2b_m1_read", 32'(s_HWRITE), 32'h0);
    check_eq("b2b_no_rv0", 32'(m0_HRVALID), 32'h0);
    check_eq("b2b_no_rv1", 32'(m1_HRVALID), 32'h0);
    exp_q.push_back(8'h3C);
    tick();
    drive_m0(HTRANS_IDLE, 1'b0, '0, '0);
    drive_m1(HTRANS_IDLE, 1'b0, '0, '0);
    s_HRDATA = 8'h3C;
    settle();
    check_eq("b2b_m1_hrvalid", 32'(m1_HRVALID), 32'h1);
    check_eq("b2b_m0_hrvalid", 32'(m0_HRVALID), 32'h0);
    check_eq("b2b_m1_hrdata", 32'(m1_HRDATA), 32'(exp_q.pop_front()));

    // Stall at hold_cnt=3 with M1 waiting
    do_reset();
    drive_m0(HTRANS_NONSEQ, 1'b1, 21'h40, 8'h01);
    tick();
    tick();
    tick();
    tick();
    drive_m1(HTRANS_NONSEQ, 1'b1, 21'h50, 8'h02);
    s_HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("stall_owner", 32'(owner), 32'h1);
      check_eq("stall_m1_hready", 32'(m1_HREADY), 32'h0);
      check_eq("stall_m0_hready", 32'(m0_HREADY), 32'h0);
      tick();
    end
    s_HREADY = 1'b1;
    settle();
    check_eq("stall_release_owner", 32'(owner), 32'h1);
    check_eq("stall_release_m0_hready", 32'(m0_HREADY), 32'h1);
    tick();
    settle();
    check_eq("stall_switch_owner", 32'(owner), 32'h2);
    check_eq("stall_switch_haddr", 32'(s_HADDR), 32'h50);
    check_eq("stall_switch_m1_hready", 32'(m1_HREADY), 32'h1);

    // Async reset right after M0's read is accepted
    do_reset();
    drive_m0(HTRANS_NONSEQ, 1'b0, 21'd5, 8'h00);
    tick();
    settle();
    check_eq("arst_pre_owner", 32'(owner), 32'h1);
    tick();
    HRESET = 1'b1;
    drive_m1(HTRANS_NONSEQ, 1'b1, 21'd6, 8'h00);
    #1;
    check_eq("arst_m0_hrvalid", 32'(m0_HRVALID), 32'h0);
    check_eq("arst_s_htrans", 32'(s_HTRANS), 32'h0);
    check_eq("arst_owner", 32'(owner), 32'h0);
    tick();
    HRESET = 1'b0;
    settle();
    check_eq("arst_bubble", 32'(owner), 32'h0);
    tick();
    settle();
    check_eq("arst_m0_wins", 32'(owner), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
